health_bar_overlay: RTL



---
 rtl/game_pkg.sv | 26 ++
 rtl/health_bar_render.sv | 66 ++++++
 rtl/health_bar_overlay.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the health bar / round-control stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package game_pkg;

    // Round state machine encoding
    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        KO        = 2'd1,
        GAME_OVER = 2'd2
    } state_e;

    // Winner encodings as seen on the winner output
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [11:0] COL_WHITE = 12'hFFF;

    // Health decrement that sticks at zero
    function automatic logic [3:0] sat_dec(input logic [3:0] h, input logic hit);
        return (hit && (h != 4'd0)) ? (h - 4'd1) : h;
    endfunction

endpackage

// File: rtl/health_bar_render.sv
// Pixel decision for the two health bars; everything outside the bar slots passes through.
// Latency: 0 cycles (pure combinational; the caller registers the result).
// Backpressure: none, one pixel in and one pixel out every cycle.
module health_bar_render
    import game_pkg::*;
#(
    parameter int              CD         = 12,
    parameter int              MAX_HEALTH = 8,
    parameter int              SEG_W      = 16,
    parameter int              BAR_Y0     = 8,
    parameter int              BAR_H      = 12,
    parameter int              BAR_L_X0   = 16,
    parameter int              BAR_R_X1   = 623,
    parameter logic [CD-1:0]   COL_L      = 12'h0F0,
    parameter logic [CD-1:0]   COL_R      = 12'hF00,
    parameter logic [CD-1:0]   COL_EMPTY  = 12'h333
) (
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic [3:0]    health_l,
    input  logic [3:0]    health_r,
    input  logic [1:0]    winner,
    input  logic          flash,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] pix
);

    // Slot edges are fixed at elaboration; only the fill edge depends on health
    localparam logic [10:0] ROW_TOP  = 11'(BAR_Y0);
    localparam logic [10:0] ROW_END  = 11'(BAR_Y0 + BAR_H);
    localparam logic [10:0] L_X0     = 11'(BAR_L_X0);
    localparam logic [10:0] L_END    = 11'(BAR_L_X0 + MAX_HEALTH * SEG_W);
    localparam logic [10:0] R_X1     = 11'(BAR_R_X1);
    localparam logic [10:0] R_START  = 11'(BAR_R_X1 - MAX_HEALTH * SEG_W);
    localparam logic [10:0] SEG_W11  = 11'(SEG_W);

    logic [10:0] l_fill_w;
    logic [10:0] r_fill_w;
    logic        in_rows;
    logic        in_l;
    logic        in_r;

    // Choose bar colour, flash white or upstream pixel for the current position
    always_comb begin
        pix      = si_rgb;
        l_fill_w = {7'd0, health_l} * SEG_W11;
        r_fill_w = {7'd0, health_r} * SEG_W11;
        in_rows  = (y >= ROW_TOP) && (y < ROW_END);
        in_l     = in_rows && (x >= L_X0) && (x < L_END);
        in_r     = in_rows && (x > R_START) && (x <= R_X1);
        if (in_l) begin
            if (x < (L_X0 + l_fill_w)) begin
                pix = (flash && (winner == WIN_L)) ? COL_WHITE : COL_L;
            end else begin
                pix = (flash && (winner == WIN_DRAW)) ? COL_WHITE : COL_EMPTY;
            end
        end else if (in_r) begin
            if (x > (R_X1 - r_fill_w)) begin
                pix = (flash && (winner == WIN_R)) ? COL_WHITE : COL_R;
            end else begin
                pix = (flash && (winner == WIN_DRAW)) ? COL_WHITE : COL_EMPTY;
            end
        end
    end

endmodule

// File: rtl/health_bar_overlay.sv
// Tracks player health, runs the play/KO/game-over round FSM and overlays the health bars.
// Latency: 1 cycle from x/y/si_rgb to so_rgb; state outputs update 1 cycle after the causing input.
// Backpressure: none, the pixel stream advances every cycle.
module health_bar_overlay
    import game_pkg::*;
#(
    parameter int              CD           = 12,
    parameter int              MAX_HEALTH   = 8,
    parameter int              SEG_W        = 16,
    parameter int              BAR_Y0       = 8,
    parameter int              BAR_H        = 12,
    parameter int              BAR_L_X0     = 16,
    parameter int              BAR_R_X1     = 623,
    parameter int              KO_FRAMES    = 120,
    parameter int              FLASH_FRAMES = 8,
    parameter logic [CD-1:0]   COL_L        = 12'h0F0,
    parameter logic [CD-1:0]   COL_R        = 12'hF00,
    parameter logic [CD-1:0]   COL_EMPTY    = 12'h333
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          hit_l,
    input  logic          hit_r,
    input  logic          restart,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb,
    output logic [3:0]    health_l,
    output logic [3:0]    health_r,
    output logic          game_over,
    output logic [1:0]    winner
);

    localparam int             FRW     = $clog2(KO_FRAMES + 1);
    localparam int             FLW     = $clog2(FLASH_FRAMES + 1);
    localparam logic [FRW-1:0] KO_LAST = FRW'(KO_FRAMES - 1);
    localparam logic [FLW-1:0] FL_LAST = FLW'(FLASH_FRAMES - 1);
    localparam logic [3:0]     MAX_H   = 4'(MAX_HEALTH);

    state_e         state_q, state_d;
    logic [3:0]     hl_q, hl_d, hr_q, hr_d;
    logic [1:0]     win_q, win_d;
    logic [FRW-1:0] frame_q, frame_d;
    logic [FLW-1:0] fcnt_q, fcnt_d;
    logic           flash_q, flash_d;
    logic [10:0]    prev_x_q, prev_y_q;
    logic [CD-1:0]  so_q, so_d;
    logic [3:0]     hl_dec, hr_dec;
    logic           tick;

    // Frame tick fires on the first origin cycle only, however long the origin is held
    always_comb begin
        tick = (x == 11'd0) && (y == 11'd0) &&
               !((prev_x_q == 11'd0) && (prev_y_q == 11'd0));
    end

    // Round FSM, health bookkeeping and frame/flash counters
    always_comb begin
        state_d = state_q;
        hl_d    = hl_q;
        hr_d    = hr_q;
        win_d   = win_q;
        frame_d = frame_q;
        fcnt_d  = fcnt_q;
        flash_d = flash_q;
        hl_dec  = sat_dec(hl_q, hit_l);
        hr_dec  = sat_dec(hr_q, hit_r);
        if (restart) begin
            state_d = PLAY;
            hl_d    = MAX_H;
            hr_d    = MAX_H;
            win_d   = WIN_NONE;
            frame_d = '0;
            fcnt_d  = '0;
            flash_d = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    hl_d = hl_dec;
                    hr_d = hr_dec;
                    if ((hl_dec == 4'd0) || (hr_dec == 4'd0)) begin
                        state_d = KO;
                        frame_d = '0;
                        fcnt_d  = '0;
                        flash_d = 1'b0;
                        if ((hl_dec == 4'd0) && (hr_dec == 4'd0)) begin
                            win_d = WIN_DRAW;
                        end else if (hr_dec == 4'd0) begin
                            win_d = WIN_L;
                        end else begin
                            win_d = WIN_R;
                        end
                    end
                end
                KO, GAME_OVER: begin
                    if (tick) begin
                        if (state_q == KO) begin
                            frame_d = frame_q + 1'b1;
                            if (frame_q == KO_LAST) begin
                                state_d = GAME_OVER;
                            end
                        end
                        if (fcnt_q == FL_LAST) begin
                            fcnt_d  = '0;
                            flash_d = !flash_q;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = PLAY;
            endcase
        end
    end

    health_bar_render #(
        .CD        (CD),
        .MAX_HEALTH(MAX_HEALTH),
        .SEG_W     (SEG_W),
        .BAR_Y0    (BAR_Y0),
        .BAR_H     (BAR_H),
        .BAR_L_X0  (BAR_L_X0),
        .BAR_R_X1  (BAR_R_X1),
        .COL_L     (COL_L),
        .COL_R     (COL_R),
        .COL_EMPTY (COL_EMPTY)
    ) u_render (
        .x       (x),
        .y       (y),
        .health_l(hl_q),
        .health_r(hr_q),
        .winner  (win_q),
        .flash   (flash_q),
        .si_rgb  (si_rgb),
        .pix     (so_d)
    );

    // State and output pixel registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAY;
            hl_q     <= MAX_H;
            hr_q     <= MAX_H;
            win_q    <= WIN_NONE;
            frame_q  <= '0;
            fcnt_q   <= '0;
            flash_q  <= 1'b0;
            prev_x_q <= '1;
            prev_y_q <= '1;
            so_q     <= '0;
        end else begin
            state_q  <= state_d;
            hl_q     <= hl_d;
            hr_q     <= hr_d;
            win_q    <= win_d;
            frame_q  <= frame_d;
            fcnt_q   <= fcnt_d;
            flash_q  <= flash_d;
            prev_x_q <= x;
            prev_y_q <= y;
            so_q     <= so_d;
        end
    end

    assign so_rgb    = so_q;
    assign health_l  = hl_q;
    assign health_r  = hr_q;
    assign winner    = win_q;
    assign game_over = (state_q == GAME_OVER);

endmodule
